harris_frame_ctrl: RTL and testbench

//  Frame-level sequencer for the Harris corner datapath.
//  - Detects frame start and clears the 5x5 line buffers.
//  - Generates the pixel shift enable and tracks pixel coordinates.
//  - Latches the trace scale per frame.
//  - Aligns the harris_feature stream to pixel coordinates, thresholds it,
//    and queues corner (x,y) records in a small FIFO for HPS/PIO readout.

---
 rtl/harris_frame_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_harris_frame_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/harris_frame_ctrl.sv
// Frame sequencer for the Harris corner datapath: line-buffer clear, pixel
// shift enable, feature/coordinate alignment, thresholding and a corner FIFO.
module harris_frame_ctrl #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int FEAT_LAT    = 2,
  parameter int CLR_CYCLES  = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_CORNERS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_N,
  input  logic [7:0]  scale_in,
  input  logic [53:0] threshold,
  input  logic [53:0] harris_feature,
  output logic        ram_clr,
  output logic        buf_shift_en,
  output logic [7:0]  scale,
  output logic        corner_valid,
  output logic [9:0]  corner_x,
  output logic [8:0]  corner_y,
  input  logic        corner_ready,
  output logic [6:0]  corner_count,
  output logic        overflow,
  output logic        frame_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [9:0]  X_MAX      = 10'(H_ACTIVE);
  localparam logic [8:0]  Y_LAST     = 9'(V_ACTIVE - 1);
  localparam logic [3:0]  CLR_LAST   = 4'(CLR_CYCLES - 1);
  localparam logic [3:0]  DRAIN_LAST = 4'(FEAT_LAT);
  localparam logic [6:0]  CNT_MAX    = 7'(MAX_CORNERS);
  localparam logic [PW:0] FIFO_FULL  = (PW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic       v;
    logic [9:0] x;
    logic [8:0] y;
  } tag_t;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } rec_t;

  logic [2:0]    state;
  logic [3:0]    phase_cnt;
  logic          vs_q, blank_q, vs_fall, blank_fall;
  logic [9:0]    x_cnt;
  logic [8:0]    y_cnt;
  tag_t          pix_tag;
  tag_t          pipe [FEAT_LAT];
  tag_t          tail;
  rec_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic          candidate, accept, drop, pop, full;

  assign vs_fall      = vs_q & ~VGA_VS;
  assign blank_fall   = blank_q & ~VGA_BLANK_N;
  assign ram_clr      = (state == S_CLEAR);
  assign frame_done   = (state == S_DONE);
  assign buf_shift_en = pix_tag.v;
  assign tail         = pipe[FEAT_LAT-1];

  // NOTE: every flop below uses non-blocking (<=) so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (enable && vs_fall) begin
          state     <= S_CLEAR;
          phase_cnt <= '0;
        end
        S_CLEAR: begin
          phase_cnt <= phase_cnt + 1'b1;
          if (phase_cnt == CLR_LAST) begin
            state     <= S_ACTIVE;
            phase_cnt <= '0;
          end
        end
        S_ACTIVE: begin
          phase_cnt <= '0;
          if (vs_fall) state <= S_CLEAR;
          else if (blank_fall && y_cnt == Y_LAST) state <= S_DRAIN;
        end
        S_DRAIN: begin
          phase_cnt <= phase_cnt + 1'b1;
          if (phase_cnt == DRAIN_LAST) state <= S_DONE;
        end
        S_DONE: begin
          phase_cnt <= '0;
          state     <= (enable && vs_fall) ? S_CLEAR : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pixel coordinates and the tag pipeline that lines them up with harris_feature.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_q    <= 1'b0;
      blank_q <= 1'b0;
      x_cnt   <= '0;
      y_cnt   <= '0;
      scale   <= '0;
      pix_tag <= '0;
      for (int i = 0; i < FEAT_LAT; i++) pipe[i] <= '0;
    end else begin
      vs_q    <= VGA_VS;
      blank_q <= VGA_BLANK_N;
      if (state == S_CLEAR) begin
        x_cnt <= '0;
        y_cnt <= '0;
        if (phase_cnt == '0) scale <= scale_in;
      end else if (state == S_ACTIVE) begin
        if (blank_fall) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + 1'b1;
        end else if (VGA_BLANK_N && x_cnt < X_MAX) begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
      pix_tag <= '{v: (state == S_ACTIVE) && VGA_BLANK_N && (x_cnt < X_MAX),
                   x: x_cnt, y: y_cnt};
      pipe[0] <= pix_tag;
      for (int i = 1; i < FEAT_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // NOTE: always_comb assigns defaults first so no path leaves a signal unassigned (no latch).
  always_comb begin
    candidate = 1'b0;
    accept    = 1'b0;
    drop      = 1'b0;
    pop       = corner_valid && corner_ready;
    full      = (fifo_cnt == FIFO_FULL);
    if ((state == S_ACTIVE || state == S_DRAIN) && tail.v &&
        tail.x >= 10'd4 && tail.y >= 9'd4 &&
        $signed(harris_feature) > $signed(threshold))
      candidate = 1'b1;
    accept = candidate && (corner_count < CNT_MAX) && (!full || pop);
    drop   = candidate && !accept;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      corner_count <= '0;
      overflow     <= 1'b0;
    end else if (state == S_CLEAR) begin
      corner_count <= '0;
      overflow     <= 1'b0;
    end else begin
      if (accept) corner_count <= corner_count + 1'b1;
      if (drop)   overflow     <= 1'b1;
    end
  end

  // NOTE: storage is not reset; the head is gated by corner_valid so outputs read 0 after reset.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {tail.x - 10'd2, tail.y - 9'd2};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign corner_valid         = (fifo_cnt != '0);
  assign {corner_x, corner_y} = corner_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_harris_frame_ctrl.sv
// Scoreboard bench for harris_frame_ctrl on a reduced 16x12 frame: expected
// corner records are queued at stimulus time and popped by a handshake monitor.
module tb_harris_frame_ctrl;

  localparam int H = 16;
  localparam int V = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        VGA_VS = 1'b1;
  logic        VGA_BLANK_N = 1'b0;
  logic [7:0]  scale_in = '0;
  logic [53:0] threshold;
  logic [53:0] harris_feature;
  logic        corner_ready = 1'b0;
  logic        ram_clr, buf_shift_en, corner_valid, overflow, frame_done;
  logic [7:0]  scale;
  logic [9:0]  corner_x;
  logic [8:0]  corner_y;
  logic [6:0]  corner_count;

  logic signed [53:0] thr = -54'sd1000;
  logic signed [53:0] fd [3];
  logic [2:0]         hd;
  logic               ready_follow = 1'b0;
  logic [18:0]        exp_q [$];

  int n_checks = 0, n_pass = 0;
  int clr_cycles = 0, done_pulses = 0, n_pops = 0;
  int clr0, done0, m_cnt, m_cand, p0;

  harris_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .reset(reset), .enable(enable), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .scale_in(scale_in), .threshold(threshold),
    .harris_feature(harris_feature), .ram_clr(ram_clr),
    .buf_shift_en(buf_shift_en), .scale(scale), .corner_valid(corner_valid),
    .corner_x(corner_x), .corner_y(corner_y), .corner_ready(corner_ready),
    .corner_count(corner_count), .overflow(overflow), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Handshake monitor: every pop is compared against the queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (ram_clr)    clr_cycles++;
      if (frame_done) done_pulses++;
      if (corner_valid && corner_ready) begin
        n_pops++;
        check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("corner_rec", {corner_x, corner_y}, exp_q.pop_front());
      end
    end
  end

  // One pixel-clock cycle; the feature for a pixel appears three cycles after it is driven.
  task automatic tick(input logic blank, input logic hot);
    logic signed [53:0] f_now;
    f_now = !blank ? thr + 54'sd100 : (hot ? thr + 54'sd1 : thr);
    VGA_BLANK_N    = blank;
    harris_feature = fd[2];
    if (ready_follow) corner_ready = hd[2];
    fd[2] = fd[1];
    fd[1] = fd[0];
    fd[0] = f_now;
    hd    = {hd[1:0], blank & hot};
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input int hx0, input int hx1, input int hy0, input int hy1,
                             input int cap, input int n_lines, input logic [7:0] sc);
    logic hot;
    m_cnt    = 0;
    m_cand   = 0;
    clr0     = clr_cycles;
    done0    = done_pulses;
    scale_in = sc;
    VGA_VS   = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    VGA_VS   = 1'b1;
    repeat (8) tick(1'b0, 1'b0);
    scale_in = ~sc;
    for (int y = 0; y < n_lines; y++) begin
      for (int x = 0; x < H; x++) begin
        hot = (x >= hx0) && (x <= hx1) && (y >= hy0) && (y <= hy1);
        if (hot && x >= 4 && y >= 4) begin
          m_cand++;
          if (m_cnt < cap) begin
            m_cnt++;
            exp_q.push_back({10'(x - 2), 9'(y - 2)});
          end
        end
        tick(1'b1, hot);
      end
      repeat (4) tick(1'b0, 1'b0);
    end
  endtask

  task automatic finish_frame(input logic [7:0] sc);
    repeat (12) tick(1'b0, 1'b0);
    check("corner_count", corner_count, m_cnt);
    check("overflow", overflow, m_cand > m_cnt);
    check("scale", scale, sc);
    check("ram_clr_cycles", clr_cycles - clr0, 4);
    check("frame_done_pulses", done_pulses - done0, 1);
  endtask

  initial begin
    threshold      = thr;
    harris_feature = thr;
    for (int i = 0; i < 3; i++) fd[i] = thr;
    hd = '0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) tick(1'b0, 1'b0);
    check("rst_ram_clr", ram_clr, 0);
    check("rst_shift_en", buf_shift_en, 0);
    check("rst_valid", corner_valid, 0);
    check("rst_count", corner_count, 0);
    check("rst_done", frame_done, 0);

    // Reset mid-ACTIVE with three queued corners.
    drive_frame(4, 6, 4, 4, 64, 6, 8'h11);
    check("pre_rst_count", corner_count, 3);
    check("pre_rst_valid", corner_valid, 1);
    check("pre_rst_scale", scale, 8'h11);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", corner_valid, 0);
    check("mid_rst_count", corner_count, 0);
    check("mid_rst_xy", {corner_x, corner_y}, 0);
    check("mid_rst_scale", scale, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_clr_shift", {ram_clr, buf_shift_en, frame_done}, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) tick(1'b0, 1'b0);

    // Single corner at (10,7) -> record (8,5); scale latched in CLEAR.
    corner_ready = 1'b1;
    drive_frame(10, 10, 7, 7, 64, V, 8'h5A);
    finish_frame(8'h5A);
    check("sb_empty_single", exp_q.size(), 0);

    // feature == threshold everywhere: strict compare yields nothing.
    drive_frame(1, 0, 1, 0, 64, V, 8'h21);
    finish_frame(8'h21);

    // Every pixel hot, consumer stalled: FIFO fills to 8, rest dropped.
    corner_ready = 1'b0;
    drive_frame(0, H - 1, 0, V - 1, 8, V, 8'h3C);
    finish_frame(8'h3C);
    check("full_valid", corner_valid, 1);
    check("full_head", {corner_x, corner_y}, {10'd2, 9'd2});

    // Full FIFO, one candidate with a pop in the same cycle.
    ready_follow = 1'b1;
    drive_frame(4, 4, 4, 4, 64, V, 8'h77);
    ready_follow = 1'b0;
    corner_ready = 1'b0;
    finish_frame(8'h77);
    check("still_full_valid", corner_valid, 1);
    p0 = n_pops;
    corner_ready = 1'b1;
    repeat (20) tick(1'b0, 1'b0);
    check("drain_pops", n_pops - p0, 8);
    check("sb_empty_drain", exp_q.size(), 0);

    // Every pixel hot, consumer always ready: capped at 64 corners.
    drive_frame(0, H - 1, 0, V - 1, 64, V, 8'hE4);
    finish_frame(8'hE4);
    repeat (10) tick(1'b0, 1'b0);
    check("sb_empty_max", exp_q.size(), 0);
    check("final_valid", corner_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
